rsa_job_ctrl: RTL

//  Host-facing job sequencer that sits upstream of the Avalon RSA engine wrapper.

---
 rtl/rsa_job_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rsa_job_ctrl.sv
// rtl/rsa_job_ctrl.sv - host job sequencer issuing per-block start pulses to the RSA engine
module rsa_job_ctrl #(
  parameter int          ADDR_W  = 32,
  parameter int          CNT_W   = 16,
  parameter int          TO_W    = 24,
  parameter logic [31:0] VERSION = 32'h5253_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic              job_start,
  output logic [ADDR_W-1:0] job_addr,
  input  logic              job_done,
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              irq_en, done, err;
  logic [ADDR_W-1:0] base, stride, cur_addr;
  logic [CNT_W-1:0]  blk_cnt, done_cnt, remaining;
  logic [TO_W-1:0]   timeout, timer;

  logic wr_ctrl, wr_status, start_req, abort_req, start_go, done_set;
  logic blk_done, batch_end, expire;

  assign wr_ctrl   = avs_write && (avs_address == 3'd0);
  assign wr_status = avs_write && (avs_address == 3'd1);
  assign abort_req = wr_ctrl && avs_writedata[2];
  assign start_req = wr_ctrl && avs_writedata[0] && !avs_writedata[2];
  assign start_go  = (state == IDLE) && start_req;
  assign done_set  = batch_end || (start_go && (blk_cnt == '0));

  assign avs_waitrequest = 1'b0;
  assign job_start       = (state == ISSUE) && !abort_req;

  // A timer value of zero inside WAIT means the timeout was disabled at issue.
  always_comb begin
    state_nxt = state;
    blk_done  = 1'b0;
    batch_end = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (start_go && (blk_cnt != '0)) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (job_done) begin
          blk_done = 1'b1;
          if (remaining == CNT_W'(1)) begin
            batch_end = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = ISSUE;
          end
        end else if (timer == TO_W'(1)) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_req) begin
      state_nxt = IDLE;
      blk_done  = 1'b0;
      batch_end = 1'b0;
      expire    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en  <= 1'b0;
      base    <= '0;
      blk_cnt <= '0;
      stride  <= ADDR_W'(32);
      timeout <= '0;
    end else if (avs_write) begin
      case (avs_address)
        3'd0:    irq_en  <= avs_writedata[1];
        3'd2:    base    <= avs_writedata[ADDR_W-1:0];
        3'd3:    blk_cnt <= avs_writedata[CNT_W-1:0];
        3'd4:    stride  <= avs_writedata[ADDR_W-1:0];
        3'd6:    timeout <= avs_writedata[TO_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      done_cnt  <= '0;
      timer     <= '0;
      job_addr  <= '0;
    end else begin
      if (start_go) begin
        cur_addr  <= base;
        remaining <= blk_cnt;
        done_cnt  <= '0;
      end else if (blk_done) begin
        cur_addr  <= cur_addr + stride;
        remaining <= remaining - CNT_W'(1);
        done_cnt  <= done_cnt + CNT_W'(1);
      end
      if (state_nxt == ISSUE) job_addr <= (state == IDLE) ? base : cur_addr + stride;
      if (state == ISSUE)                         timer <= timeout;
      else if ((state == WAIT) && (timer != '0))  timer <= timer - TO_W'(1);
    end
  end

  // Hardware set has priority over a same-cycle W1C.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
      err  <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (done_set)                                          done <= 1'b1;
      else if (start_go || (wr_status && avs_writedata[1]))  done <= 1'b0;
      if (expire)                                            err  <= 1'b1;
      else if (start_go || (wr_status && avs_writedata[2]))  err  <= 1'b0;
      irq <= irq_en && (done || err);
    end
  end

  always_comb begin
    avs_readdata = '0;
    if (avs_read && reset) begin
      case (avs_address)
        3'd0:    avs_readdata = {30'b0, irq_en, 1'b0};
        3'd1:    avs_readdata = {29'b0, err, done, state != IDLE};
        3'd2:    avs_readdata = 32'(base);
        3'd3:    avs_readdata = 32'(blk_cnt);
        3'd4:    avs_readdata = 32'(stride);
        3'd5:    avs_readdata = 32'(done_cnt);
        3'd6:    avs_readdata = 32'(timeout);
        default: avs_readdata = VERSION;
      endcase
    end
  end

endmodule
